// File: rtl/seq_cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM states,
// the one-hot {eq,gt,lt} result word and step/counter sizing helpers.
package seq_cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Result word is one-hot {eq, gt, lt}; all-zero means "no valid result".
   typedef logic [2:0] res_t;

   localparam int RES_EQ_BIT = 2;
   localparam int RES_GT_BIT = 1;
   localparam int RES_LT_BIT = 0;

   localparam res_t RES_NONE = 3'b000;
   localparam res_t RES_EQ   = 3'b100;
   localparam res_t RES_GT   = 3'b010;
   localparam res_t RES_LT   = 3'b001;

   function automatic int calc_steps(input int width, input int bpc);
      return width / bpc;
   endfunction

   function automatic int calc_cnt_w(input int steps);
      return (steps <= 1) ? 1 : $clog2(steps);
   endfunction

endpackage

// File: rtl/slice_compare.sv
// One cascade stage of the MSB-first magnitude compare: folds a BPC-bit
// unsigned slice into an incoming {eq,gt,lt} state. A decided state passes through.
module slice_compare
   import seq_cmp_pkg::*;
#(
   parameter int BPC = 1
) (
   input  logic [BPC-1:0] i_a,
   input  logic [BPC-1:0] i_b,
   input  res_t           i_acc,
   output res_t           o_acc
);

   logic [BPC:0] w_eq;
   logic [BPC:0] w_gt;
   logic [BPC:0] w_lt;

   assign w_eq[0] = i_acc[RES_EQ_BIT];
   assign w_gt[0] = i_acc[RES_GT_BIT];
   assign w_lt[0] = i_acc[RES_LT_BIT];

   // Bit ripple from the slice MSB down; only the first differing bit decides.
   genvar gi;
   generate
      for (gi = 0; gi < BPC; gi++) begin : g_bit
         localparam int BI = BPC - 1 - gi;
         assign w_eq[gi+1] = w_eq[gi] & ~(i_a[BI] ^ i_b[BI]);
         assign w_gt[gi+1] = w_gt[gi] | (w_eq[gi] &  i_a[BI] & ~i_b[BI]);
         assign w_lt[gi+1] = w_lt[gi] | (w_eq[gi] & ~i_a[BI] &  i_b[BI]);
      end
   endgenerate

   assign o_acc = {w_eq[BPC], w_gt[BPC], w_lt[BPC]};

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with start/done handshake and
// runtime signed mode. Define SEQ_CMP_EARLY_EXIT_EN to stop on the first differing slice.
module seq_magnitude_comparator
   import seq_cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int BPC   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int STEPS = calc_steps(WIDTH, BPC);
   localparam int CNT_W = calc_cnt_w(STEPS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_signed;
   logic [CNT_W-1:0] r_cnt;
   res_t             r_acc;
   res_t             r_res;
   logic             r_busy;
   logic             r_done;

   logic [BPC-1:0]   w_slice_a;
   logic [BPC-1:0]   w_slice_b;
   logic             w_first;
   res_t             w_acc_next;
   logic             w_exit;

   assign w_first = (r_cnt == CNT_LAST);

   // Flipping both MSBs on the first step maps two's complement order onto unsigned order.
   always_comb begin
      w_slice_a = r_a[WIDTH-1 -: BPC];
      w_slice_b = r_b[WIDTH-1 -: BPC];
      w_slice_a[BPC-1] = r_a[WIDTH-1] ^ (r_signed & w_first);
      w_slice_b[BPC-1] = r_b[WIDTH-1] ^ (r_signed & w_first);
   end

   slice_compare #(
      .BPC (BPC)
   ) u_slice (
      .i_a   (w_slice_a),
      .i_b   (w_slice_b),
      .i_acc (r_acc),
      .o_acc (w_acc_next)
   );

`ifdef SEQ_CMP_EARLY_EXIT_EN
   assign w_exit = (r_cnt == '0) || !w_acc_next[RES_EQ_BIT];
`else
   assign w_exit = (r_cnt == '0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= RES_NONE;
         r_res    <= RES_NONE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_signed <= signed_mode;
                  r_acc    <= RES_EQ;
                  r_cnt    <= CNT_LAST;
                  r_res    <= RES_NONE;
                  r_busy   <= 1'b1;
                  r_state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_acc <= w_acc_next;
               r_a   <= r_a << BPC;
               r_b   <= r_b << BPC;
               r_cnt <= r_cnt - 1'b1;
               if (w_exit) begin
                  r_res   <= w_acc_next;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign eq   = r_res[RES_EQ_BIT];
   assign gt   = r_res[RES_GT_BIT];
   assign lt   = r_res[RES_LT_BIT];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench: three comparator configurations (16/1, 16/4, 8/8) checked
// against an arithmetic reference compare and a latency model.
module tb_seq_magnitude_comparator;

   localparam int NI = 3;
   localparam int W_OF [NI] = '{16, 16, 8};
   localparam int B_OF [NI] = '{1, 4, 8};

   logic        clk;
   logic        rst;
   logic        start_v [NI];
   logic [15:0] a_v     [NI];
   logic [15:0] b_v     [NI];
   logic        sm_v    [NI];
   logic        busy_o  [NI];
   logic        done_o  [NI];
   logic        eq_o    [NI];
   logic        gt_o    [NI];
   logic        lt_o    [NI];

   int passed = 0;
   int total  = 0;

   seq_magnitude_comparator #(.WIDTH(16), .BPC(1)) u_w16b1 (
      .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
      .signed_mode(sm_v[0]), .busy(busy_o[0]), .done(done_o[0]),
      .eq(eq_o[0]), .gt(gt_o[0]), .lt(lt_o[0])
   );

   seq_magnitude_comparator #(.WIDTH(16), .BPC(4)) u_w16b4 (
      .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
      .signed_mode(sm_v[1]), .busy(busy_o[1]), .done(done_o[1]),
      .eq(eq_o[1]), .gt(gt_o[1]), .lt(lt_o[1])
   );

   seq_magnitude_comparator #(.WIDTH(8), .BPC(8)) u_w8b8 (
      .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][7:0]), .b(b_v[2][7:0]),
      .signed_mode(sm_v[2]), .busy(busy_o[2]), .done(done_o[2]),
      .eq(eq_o[2]), .gt(gt_o[2]), .lt(lt_o[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference: interpret operands as integers and compare them.
   function automatic logic [2:0] ref_cmp(input int w, input logic [15:0] av,
                                          input logic [15:0] bv, input logic sm);
      longint span, va, vb;
      span = longint'(1) << w;
      va = longint'(av) & (span - 1);
      vb = longint'(bv) & (span - 1);
      if (sm && va >= span / 2) va = va - span;
      if (sm && vb >= span / 2) vb = vb - span;
      if (va == vb) return 3'b100;
      else if (va > vb) return 3'b010;
      else return 3'b001;
   endfunction

   // Cycle (counted from the start-sampling edge) in which done is expected.
   function automatic int ref_lat(input int w, input int bpc,
                                  input logic [15:0] av, input logic [15:0] bv);
      int steps;
      longint diff;
      steps = w / bpc;
      diff = (longint'(av ^ bv)) & ((longint'(1) << w) - 1);
`ifdef SEQ_CMP_EARLY_EXIT_EN
      for (int s = 1; s <= steps; s++)
         if (((diff >> (w - s * bpc)) & ((longint'(1) << bpc) - 1)) != 0) return s + 1;
`else
      if (diff < 0) return -1;
`endif
      return steps + 1;
   endfunction

   // Called at a negedge; start is sampled on the following rising edge (cycle 0).
   task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                        input logic sm, input string tag);
      logic [2:0] exp_res, res;
      int exp_lat, lat;
      bit busy_bad;
      exp_res = ref_cmp(W_OF[k], av, bv, sm);
      exp_lat = ref_lat(W_OF[k], B_OF[k], av, bv);
      a_v[k] = av; b_v[k] = bv; sm_v[k] = sm; start_v[k] = 1'b1;
      lat = -1; res = 3'b000; busy_bad = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start_v[k] = 1'b0;
            a_v[k] = 16'($urandom);
            b_v[k] = 16'($urandom);
            sm_v[k] = ~sm;
         end
         if (busy_o[k] !== 1'b1) busy_bad = 1'b1;
         if (done_o[k] === 1'b1) begin
            lat = c;
            res = {eq_o[k], gt_o[k], lt_o[k]};
            break;
         end
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, {29'd0, res}, {29'd0, exp_res});
      chk({tag, "_busy"}, {31'd0, busy_bad}, 32'd0);
      @(negedge clk);
      chk({tag, "_hold"}, {27'd0, busy_o[k], done_o[k], eq_o[k], gt_o[k], lt_o[k]},
          {27'd0, 2'b00, exp_res});
      $display("op %s k=%0d a=%h b=%h sm=%0d res=%b lat=%0d", tag, k, av, bv, sm, res, lat);
   endtask

   initial begin
      int ndone, first_done;
      logic [2:0] res;
      logic [15:0] ra, rb;
      int mode;

      rst = 1'b1;
      for (int k = 0; k < NI; k++) begin
         start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; sm_v[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++)
         chk($sformatf("reset%0d", k),
             {27'd0, busy_o[k], done_o[k], eq_o[k], gt_o[k], lt_o[k]}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_op(0, 16'h1234, 16'h1234, 1'b0, "eq_1234");
      do_op(1, 16'hFFFF, 16'h0001, 1'b1, "signed_m1_vs_1");
      do_op(1, 16'hFFFF, 16'h0001, 1'b0, "unsigned_ffff_vs_1");
      do_op(0, 16'h8000, 16'h0000, 1'b0, "msb_only");
      do_op(2, 16'h007F, 16'h0080, 1'b1, "w8_signed");

      // Stray starts in cycle 3 and in the done cycle must be ignored.
      a_v[0] = 16'h00A5; b_v[0] = 16'h00A5; sm_v[0] = 1'b0; start_v[0] = 1'b1;
      ndone = 0; first_done = -1; res = 3'b000;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start_v[0] = (c == 3);
         if (c == 3) begin a_v[0] = 16'hFFFF; b_v[0] = 16'h0000; end
         if (done_o[0] === 1'b1) begin
            ndone++;
            if (first_done < 0) begin
               first_done = c;
               res = {eq_o[0], gt_o[0], lt_o[0]};
               start_v[0] = 1'b1;
            end
         end
      end
      chk("ignored_ndone", ndone, 1);
      chk("ignored_lat", first_done, 17);
      chk("ignored_res", {29'd0, res}, 32'd4);
      chk("ignored_idle", {31'd0, busy_o[0]}, 32'd0);
      $display("op ignored_starts ndone=%0d lat=%0d res=%b", ndone, first_done, res);
      do_op(0, 16'h0001, 16'h0002, 1'b0, "after_ignored");

      // Reset in the middle of a run abandons the operation.
      a_v[0] = 16'h0001; b_v[0] = 16'h0002; sm_v[0] = 1'b0; start_v[0] = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) start_v[0] = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_state", {27'd0, busy_o[0], done_o[0], eq_o[0], gt_o[0], lt_o[0]}, 32'd0);
      rst = 1'b0;
      ndone = 0;
      repeat (25) begin
         @(negedge clk);
         if (done_o[0] === 1'b1) ndone++;
      end
      chk("midrst_nodone", ndone, 0);
      $display("op midrun_reset dones_after=%0d", ndone);
      do_op(0, 16'h0000, 16'h0000, 1'b0, "post_rst");

      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 0) rb = ra;
            else if (mode == 1) rb = ra ^ (16'd1 << $urandom_range(0, W_OF[k] - 1));
            else rb = 16'($urandom);
            if (W_OF[k] == 8) begin ra[15:8] = '0; rb[15:8] = '0; end
            do_op(k, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_%0d", k, i));
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
